lcd_char_writer: RTL and testbench

Parametrised HD44780-style character LCD controller, the successor to the fixed-function `lcd_display_input` driver. It accepts characters over a valid/ready stream into an internal FIFO and runs the power-up initialisation sequence. It then writes each character with correct enable-pulse and busy timing, wrapping the cursor automatically across one or two lines. It sits between the A5/1 encrypt/decrypt datapath, which produces plaintext, ciphertext or keystream characters, and the board LCD pins.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_char_writer_if.sv | 32 +++
 rtl/lcd_char_fifo.sv | 52 +++++
 rtl/lcd_char_writer.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_char_writer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command constants, sequencer/engine state enums, hex helper.
// No ports; imported by the lcd_char_writer files.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_ON    = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_ADDR_L0   = 8'h80;
  localparam logic [7:0] LCD_ADDR_L1   = 8'hC0;

  typedef enum logic [3:0] {
    S_POWERUP,
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_INIT3,
    S_READY,
    S_CHAR,
    S_NEWLINE,
    S_CLEAR
  } seq_t;

  typedef enum logic [2:0] {
    E_IDLE,
    E_SETUP,
    E_PULSE,
    E_HOLD,
    E_WAIT
  } eng_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// lcd_char_writer_if: character stream in_data/in_valid/in_ready (+ in_hex
// when LCD_HEX_EN is defined). master = producer, slave = lcd_char_writer.
interface lcd_char_writer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
`ifdef LCD_HEX_EN
  logic       in_hex;

  modport master (
    output in_data, in_valid, in_hex,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid, in_hex,
    output in_ready
  );
`else
  modport master (
    output in_data, in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready
  );
`endif

endinterface

// File: rtl/lcd_char_fifo.sv
// lcd_char_fifo: synchronous FIFO, WIDTH x DEPTH (power of two, >=2).
// Ports: clock, reset, push/wdata, pop/rdata, full, empty.
module lcd_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // a pop frees the slot, so push is allowed even when full
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push)
        wp <= wp + ONE;
      if (do_pop)
        rp <= rp + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: HD44780 char LCD controller (init, FIFO, cursor wrap).
// Ports: clock, reset, bus (stream slave), clear, lcd_* pins, init_done, busy. Option: LCD_HEX_EN.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int NUM_CHARS    = 16,
  parameter int LINES        = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int EN_CYCLES    = 12,
  parameter int CMD_WAIT     = 2000,
  parameter int CLEAR_WAIT   = 82000,
  parameter int POWERUP_WAIT = 750000
) (
  input  logic              clock,
  input  logic              reset,
  lcd_char_writer_if.slave  bus,
  input  logic              clear,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              lcd_on,
  output logic              init_done,
  output logic              busy
);

  localparam int MAX_A = (POWERUP_WAIT > CLEAR_WAIT) ?
                         POWERUP_WAIT : CLEAR_WAIT;
  localparam int MAX_B = (CMD_WAIT > EN_CYCLES) ?
                         CMD_WAIT : EN_CYCLES;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CTR_W = $clog2(MAX_W + 1);
  localparam int CW    = $clog2(NUM_CHARS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_CHARS - 1);

  seq_t             seq;
  eng_t             eng;
  logic [CTR_W-1:0] cnt;
  logic [CW-1:0]    col;
  logic             line;
  logic             clr_pend;

  logic       push;
  logic       pop;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       ready_idle;
  logic       wait_done;
  logic       is_clr;
  logic       next_line;
  logic [7:0] addr;

`ifdef LCD_HEX_EN
  assign wdata = bus.in_hex ? hex_ascii(bus.in_data[3:0])
                            : bus.in_data;
`else
  assign wdata = bus.in_data;
`endif

  assign bus.in_ready = !full && !reset;
  assign push         = bus.in_valid && bus.in_ready;

  assign ready_idle = (seq == S_READY) && (eng == E_IDLE);
  assign pop        = ready_idle && !clr_pend && !empty;
  assign busy       = !ready_idle;
  assign wait_done  = (eng == E_WAIT) && (cnt == '0);
  assign is_clr     = !lcd_rs && (lcd_data == LCD_CMD_CLEAR);
  assign next_line  = (LINES == 2) ? ~line : 1'b0;
  assign addr       = next_line ? LCD_ADDR_L1 : LCD_ADDR_L0;

  assign lcd_rw = 1'b0;
  assign lcd_on = 1'b1;

  lcd_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // a new pulse wins over service so it is never lost
  always_ff @(posedge clock) begin
    if (reset)
      clr_pend <= 1'b0;
    else if (clear)
      clr_pend <= 1'b1;
    else if (ready_idle)
      clr_pend <= 1'b0;
  end

  // engine steps first; sequencer starts overwrite eng with E_SETUP
  always_ff @(posedge clock) begin
    if (reset) begin
      seq       <= S_POWERUP;
      eng       <= E_IDLE;
      cnt       <= CTR_W'(POWERUP_WAIT - 1);
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      init_done <= 1'b0;
      col       <= '0;
      line      <= 1'b0;
    end else begin
      unique case (eng)
        E_IDLE: ;
        E_SETUP: begin
          eng    <= E_PULSE;
          lcd_en <= 1'b1;
          cnt    <= CTR_W'(EN_CYCLES - 1);
        end
        E_PULSE: begin
          if (cnt == '0) begin
            eng    <= E_HOLD;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        E_HOLD: begin
          eng <= E_WAIT;
          cnt <= is_clr ? CTR_W'(CLEAR_WAIT - 1)
                        : CTR_W'(CMD_WAIT - 1);
        end
        E_WAIT: begin
          if (cnt == '0)
            eng <= E_IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: eng <= E_IDLE;
      endcase

      unique case (seq)
        S_POWERUP: begin
          if (cnt == '0) begin
            seq      <= S_INIT0;
            eng      <= E_SETUP;
            lcd_data <= LCD_CMD_FUNC;
            lcd_rs   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_INIT0: if (wait_done) begin
          seq      <= S_INIT1;
          eng      <= E_SETUP;
          lcd_data <= LCD_CMD_ON;
        end
        S_INIT1: if (wait_done) begin
          seq      <= S_INIT2;
          eng      <= E_SETUP;
          lcd_data <= LCD_CMD_CLEAR;
        end
        S_INIT2: if (wait_done) begin
          seq      <= S_INIT3;
          eng      <= E_SETUP;
          lcd_data <= LCD_CMD_ENTRY;
        end
        S_INIT3: if (wait_done) begin
          seq       <= S_READY;
          init_done <= 1'b1;
        end
        S_READY: begin
          if (clr_pend) begin
            seq      <= S_CLEAR;
            eng      <= E_SETUP;
            lcd_data <= LCD_CMD_CLEAR;
            lcd_rs   <= 1'b0;
            col      <= '0;
            line     <= 1'b0;
          end else if (!empty) begin
            seq      <= S_CHAR;
            eng      <= E_SETUP;
            lcd_data <= rdata;
            lcd_rs   <= 1'b1;
          end
        end
        S_CHAR: if (wait_done) begin
          if (col == LAST_COL) begin
            col      <= '0;
            line     <= next_line;
            seq      <= S_NEWLINE;
            eng      <= E_SETUP;
            lcd_data <= addr;
            lcd_rs   <= 1'b0;
          end else begin
            col <= col + 1'b1;
            seq <= S_READY;
          end
        end
        S_NEWLINE: if (wait_done) seq <= S_READY;
        S_CLEAR:   if (wait_done) seq <= S_READY;
        default:   seq <= S_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: directed bench with a transaction-level LCD model.
// Checks command/data order, pulse width, wait lengths and reset behaviour.
module tb_lcd_char_writer;

  localparam int NCH = 4;
  localparam int NL  = 2;
  localparam int ENC = 2;
  localparam int CMW = 4;
  localparam int CLW = 10;
  localparam int PWW = 20;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wt;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic       init_done;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  txn_t exp_q[$];
  int   m_col;
  int   m_line;

  lcd_char_writer_if bus ();

  lcd_char_writer #(
    .NUM_CHARS    (NCH),
    .LINES        (NL),
    .FIFO_DEPTH   (8),
    .EN_CYCLES    (ENC),
    .CMD_WAIT     (CMW),
    .CLEAR_WAIT   (CLW),
    .POWERUP_WAIT (PWW)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .clear     (clear),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_on    (lcd_on),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [7:0] m_conv(input logic [7:0] d,
                                        input logic h);
    string hs;
    hs = "0123456789ABCDEF";
    if (h)
      return hs[d[3:0]];
    return d;
  endfunction

  task automatic exp_add(input logic rs, input logic [7:0] d);
    txn_t t;
    t.rs   = rs;
    t.data = d;
    t.wt   = (!rs && d == 8'h01) ? CLW : CMW;
    exp_q.push_back(t);
  endtask

  task automatic exp_init();
    exp_add(1'b0, 8'h38);
    exp_add(1'b0, 8'h0C);
    exp_add(1'b0, 8'h01);
    exp_add(1'b0, 8'h06);
    m_col  = 0;
    m_line = 0;
  endtask

  task automatic exp_clear();
    exp_add(1'b0, 8'h01);
    m_col  = 0;
    m_line = 0;
  endtask

  task automatic exp_char(input logic [7:0] d);
    exp_add(1'b1, d);
    m_col++;
    if (m_col == NCH) begin
      m_col  = 0;
      m_line = (m_line + 1) % NL;
      exp_add(1'b0, (m_line == 0) ? 8'h80 : 8'hC0);
    end
  endtask

  // ---------------- monitor ----------------
  int   ph = 0;
  int   wid;
  int   tail;
  txn_t cur;

  task automatic stab();
    chk("hold_data", lcd_data, cur.data);
    chk("hold_rs", lcd_rs, cur.rs);
  endtask

  task automatic start_txn();
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_txn: got rs=%0d data=0x%0h, expected none at %0t",
               lcd_rs, lcd_data, $time);
      cur.rs   = lcd_rs;
      cur.data = lcd_data;
      cur.wt   = CMW;
    end else begin
      cur = exp_q.pop_front();
      chk("txn_rs", lcd_rs, cur.rs);
      chk("txn_data", lcd_data, cur.data);
    end
    wid = 1;
    ph  = 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
    end else begin
      chk("lcd_rw", lcd_rw, 0);
      chk("lcd_on", lcd_on, 1);
      if (lcd_en)
        chk("en_busy", busy, 1);
      case (ph)
        0: if (lcd_en) start_txn();
        1: begin
          if (lcd_en) begin
            wid++;
            stab();
          end else begin
            chk("en_width", wid, ENC);
            tail = 1;
            stab();
            ph = 2;
          end
        end
        default: begin
          if (lcd_en) begin
            chk("txn_gap_ok", tail >= cur.wt + 2, 1);
            start_txn();
          end else if (!busy) begin
            chk("hold_plus_wait", tail, cur.wt + 1);
            ph = 0;
          end else begin
            tail++;
            if (tail <= cur.wt + 1)
              stab();
          end
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_h(input logic [7:0] d, input logic h,
                        output int stalls);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef LCD_HEX_EN
    bus.in_hex   = h;
`endif
    stalls = 0;
    while (!bus.in_ready && stalls < 1000) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: got no in_ready, expected accept");
    end else begin
      @(posedge clk);
      #1;
      exp_char(m_conv(d, h));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int s;
    push_h(d, 1'b0, s);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 3000);
    chk("drain_in_time", n < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_en && n < 200);
    chk("en_seen", lcd_en, 1);
  endtask

  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1);
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_cycle", n, 58);
    chk("idle_after_init", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_lcd_data"}, lcd_data, 8'h00);
    chk({tag, "_lcd_rs"}, lcd_rs, 0);
    chk({tag, "_lcd_en"}, lcd_en, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int s;
    int first_stall;
    int n;
    rst          = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
`ifdef LCD_HEX_EN
    bus.in_hex   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_init();
    wait_init();

    // single char, busy length 1+2+1+4
    push(8'h48);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("char_busy_len", n, 8);
    drain();

    // two clears during a char, two chars queued
    push(8'h61);
    wait_en();
    @(posedge clk);
    #1;
    pulse_clear();
    @(posedge clk);
    #1;
    pulse_clear();
    exp_clear();
    push(8'h78);
    push(8'h79);
    drain();

    // wrap across both lines
    pulse_clear();
    exp_clear();
    for (int i = 0; i < 9; i++) begin
      push(8'h30 + 8'(i));
      if (i == 3) begin
        chk("model_nl1_data", exp_q[$].data, 8'hC0);
        chk("model_nl1_rs", exp_q[$].rs, 0);
      end
      if (i == 7)
        chk("model_nl0_data", exp_q[$].data, 8'h80);
    end
    chk("model_col_after9", m_col, 1);
    chk("model_line_after9", m_line, 0);
    drain();

    // burst of 12 into a depth-8 FIFO
    first_stall = -1;
    for (int i = 0; i < 12; i++) begin
      push_h(8'h41 + 8'(i), 1'b0, s);
      if (s > 0 && first_stall < 0)
        first_stall = i;
    end
    chk("burst_first_stall", first_stall, 9);
    drain();

`ifdef LCD_HEX_EN
    chk("model_hex_0b", m_conv(8'h0B, 1'b1), 8'h42);
    push_h(8'h0B, 1'b1, s);
    push_h(8'hFA, 1'b1, s);
    push_h(8'h3A, 1'b0, s);
    drain();
`endif

    // reset mid-pulse with a queued char and a pending clear
    push(8'h5A);
    push(8'h51);
    pulse_clear();
    wait_en();
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_init();
    wait_init();
    repeat (30) @(negedge clk);
    chk("empty_after_reset", busy, 0);
    chk("no_leftover_txn", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
